// File: rtl/m3_lossless_decoder.sv
// m3_lossless_decoder
//
// Lossless decode stage that sits in front of milestone2. It reads a 3-word header and a
// variable-length coefficient stream from SRAM. It expands the codes into zigzag-ordered 8x8
// blocks and writes one 16-bit pre-IDCT word per coefficient into the output region.
//
// Build option:
//   M3_DEQUANT_EN  defined   : each coefficient is shifted left by a Q0/Q1 amount chosen by r+c.
//                  undefined : the raw coefficient is written sign-extended; Qsel is ignored.
//
// Parameters:
//   STREAM_BASE  address of header word 0 (the code stream starts 3 words later)
//   OUT_BASE     address of coefficient 0 of block 0
//   NUM_BLOCKS   number of 8x8 blocks decoded before finishing
//
// Ports:
//   Clock            system clock, rising edge
//   resetn           asynchronous active-low reset
//   M3_enable        level from the top FSM; starts the stage and releases it from DONE
//   M3_finish        high while in S_M3_DONE
//   M3_error         sticky header-mismatch flag, cleared on the next start
//   SRAM_we_n        active-low write strobe, low for one cycle per coefficient
//   SRAM_address     SRAM word address (reads and writes)
//   SRAM_write_data  coefficient being written
//   SRAM_read_data   read data, valid two cycles after the address was presented

module m3_lossless_decoder #(
    parameter logic [17:0] STREAM_BASE = 18'd0,
    parameter logic [17:0] OUT_BASE    = 18'd76800,
    parameter logic [13:0] NUM_BLOCKS  = 14'd1200
) (
    input  logic        Clock,
    input  logic        resetn,
    input  logic        M3_enable,
    output logic        M3_finish,
    output logic        M3_error,
    output logic        SRAM_we_n,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    input  logic [15:0] SRAM_read_data
);

    typedef enum logic [2:0] {
        S_M3_IDLE,
        S_M3_HDR,
        S_M3_FILL,
        S_M3_DECODE,
        S_M3_ZERO,
        S_M3_DONE
    } state_e;

    state_e      state_q, state_d;
    logic        finish_q, finish_d;
    logic        error_q, error_d;
    logic        we_n_q, we_n_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] bitbuf_q, bitbuf_d;    // valid bits are left-aligned at bit 31
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic [17:0] rd_ptr_q, rd_ptr_d;    // next stream word to fetch
    logic [2:0]  phase_q, phase_d;      // cycle counter inside HDR and FILL
    logic        hdr_bad_q, hdr_bad_d;
    logic [5:0]  k_q, k_d;              // zigzag scan index within the current block
    logic [13:0] blk_q, blk_d;
    logic [6:0]  zcnt_q, zcnt_d;        // zeros still to write in S_M3_ZERO
    logic        all_done_q, all_done_d;
`ifdef M3_DEQUANT_EN
    logic        qsel_q, qsel_d;
`endif

    // Zigzag scan index -> raster position {r[2:0], c[2:0]}.
    function automatic logic [5:0] zigzag(input logic [5:0] k);
        logic [5:0] rc;
        rc = 6'd0;
        case (k)
            6'd0:  rc = 6'd0;   6'd1:  rc = 6'd1;   6'd2:  rc = 6'd8;   6'd3:  rc = 6'd16;
            6'd4:  rc = 6'd9;   6'd5:  rc = 6'd2;   6'd6:  rc = 6'd3;   6'd7:  rc = 6'd10;
            6'd8:  rc = 6'd17;  6'd9:  rc = 6'd24;  6'd10: rc = 6'd32;  6'd11: rc = 6'd25;
            6'd12: rc = 6'd18;  6'd13: rc = 6'd11;  6'd14: rc = 6'd4;   6'd15: rc = 6'd5;
            6'd16: rc = 6'd12;  6'd17: rc = 6'd19;  6'd18: rc = 6'd26;  6'd19: rc = 6'd33;
            6'd20: rc = 6'd40;  6'd21: rc = 6'd48;  6'd22: rc = 6'd41;  6'd23: rc = 6'd34;
            6'd24: rc = 6'd27;  6'd25: rc = 6'd20;  6'd26: rc = 6'd13;  6'd27: rc = 6'd6;
            6'd28: rc = 6'd7;   6'd29: rc = 6'd14;  6'd30: rc = 6'd21;  6'd31: rc = 6'd28;
            6'd32: rc = 6'd35;  6'd33: rc = 6'd42;  6'd34: rc = 6'd49;  6'd35: rc = 6'd56;
            6'd36: rc = 6'd57;  6'd37: rc = 6'd50;  6'd38: rc = 6'd43;  6'd39: rc = 6'd36;
            6'd40: rc = 6'd29;  6'd41: rc = 6'd22;  6'd42: rc = 6'd15;  6'd43: rc = 6'd23;
            6'd44: rc = 6'd30;  6'd45: rc = 6'd37;  6'd46: rc = 6'd44;  6'd47: rc = 6'd51;
            6'd48: rc = 6'd58;  6'd49: rc = 6'd59;  6'd50: rc = 6'd52;  6'd51: rc = 6'd45;
            6'd52: rc = 6'd38;  6'd53: rc = 6'd31;  6'd54: rc = 6'd39;  6'd55: rc = 6'd46;
            6'd56: rc = 6'd53;  6'd57: rc = 6'd60;  6'd58: rc = 6'd61;  6'd59: rc = 6'd54;
            6'd60: rc = 6'd47;  6'd61: rc = 6'd55;  6'd62: rc = 6'd62;  6'd63: rc = 6'd63;
            default: rc = 6'd0;
        endcase
        return rc;
    endfunction

`ifdef M3_DEQUANT_EN
    // Left-shift amount for a coefficient at diagonal r+c (0..14) under table Q0 or Q1.
    function automatic logic [2:0] q_shift(input logic qsel, input logic [3:0] s);
        logic [2:0] sh;
        if (s == 4'd0)       sh = 3'd3;
        else if (s == 4'd1)  sh = qsel ? 3'd1 : 3'd2;
        else if (s <= 4'd3)  sh = qsel ? 3'd1 : 3'd3;
        else if (s <= 4'd5)  sh = qsel ? 3'd2 : 3'd4;
        else if (s <= 4'd7)  sh = qsel ? 3'd2 : 3'd5;
        else                 sh = qsel ? 3'd3 : 3'd6;
        return sh;
    endfunction
`endif

    logic [1:0]  prefix;
    logic [15:0] coef_sext;
    logic [15:0] coef_out;
    logic [6:0]  run_len;
    logic [6:0]  remain;
    logic [6:0]  run_clip;
    logic [5:0]  zz_rc;
    logic [17:0] wr_addr;
    logic        adv;

    assign prefix    = bitbuf_q[31:30];
    // 01 carries a 6-bit value, 00 a 3-bit value; both start right after the prefix.
    assign coef_sext = prefix[0] ? {{10{bitbuf_q[29]}}, bitbuf_q[29:24]}
                                 : {{13{bitbuf_q[29]}}, bitbuf_q[29:27]};
    assign run_len   = (bitbuf_q[29:27] == 3'd0) ? 7'd8 : {4'd0, bitbuf_q[29:27]};
    assign remain    = 7'd64 - {1'b0, k_q};
    assign run_clip  = (run_len > remain) ? remain : run_len;
    assign zz_rc     = zigzag(k_q);
    // blk*64 + r*8 + c is just the concatenation {blk, r, c}.
    assign wr_addr   = OUT_BASE + 18'({blk_q, zz_rc});

`ifdef M3_DEQUANT_EN
    logic [3:0] rc_sum;
    assign rc_sum   = {1'b0, zz_rc[5:3]} + {1'b0, zz_rc[2:0]};
    assign coef_out = coef_sext << q_shift(qsel_q, rc_sum);
`else
    assign coef_out = coef_sext;
`endif

    always_comb begin
        state_d    = state_q;
        finish_d   = finish_q;
        error_d    = error_q;
        we_n_d     = 1'b1;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        bitbuf_d   = bitbuf_q;
        bitcnt_d   = bitcnt_q;
        rd_ptr_d   = rd_ptr_q;
        phase_d    = phase_q;
        hdr_bad_d  = hdr_bad_q;
        k_d        = k_q;
        blk_d      = blk_q;
        zcnt_d     = zcnt_q;
        all_done_d = all_done_q;
`ifdef M3_DEQUANT_EN
        qsel_d     = qsel_q;
`endif
        adv        = 1'b0;

        case (state_q)
            S_M3_IDLE: begin
                finish_d = 1'b0;
                if (M3_enable) begin
                    state_d    = S_M3_HDR;
                    addr_d     = STREAM_BASE;
                    phase_d    = 3'd0;
                    error_d    = 1'b0;
                    hdr_bad_d  = 1'b0;
                    bitbuf_d   = 32'd0;
                    bitcnt_d   = 6'd0;
                    rd_ptr_d   = STREAM_BASE + 18'd3;
                    k_d        = 6'd0;
                    blk_d      = 14'd0;
                    zcnt_d     = 7'd0;
                    all_done_d = 1'b0;
                end
            end

            // Addresses go out in phases 0..2; word n is on the bus in phase n+2.
            S_M3_HDR: begin
                phase_d = phase_q + 3'd1;
                if (phase_q < 3'd2) begin
                    addr_d = addr_q + 18'd1;
                end
                if (phase_q == 3'd2 && SRAM_read_data != 16'hDEAD) begin
                    hdr_bad_d = 1'b1;
                end
                if (phase_q == 3'd3 && SRAM_read_data != 16'hBEEF) begin
                    hdr_bad_d = 1'b1;
                end
                if (phase_q == 3'd4) begin
`ifdef M3_DEQUANT_EN
                    qsel_d = SRAM_read_data[15];
`endif
                    if (hdr_bad_q) begin
                        error_d  = 1'b1;
                        finish_d = 1'b1;
                        state_d  = S_M3_DONE;
                    end else begin
                        state_d = S_M3_FILL;
                        addr_d  = rd_ptr_q;
                        phase_d = 3'd0;
                    end
                end
            end

            // Phase 0 presents the address, phase 2 sees the data.
            S_M3_FILL: begin
                phase_d = phase_q + 3'd1;
                if (phase_q == 3'd2) begin
                    bitbuf_d = bitbuf_q | ({SRAM_read_data, 16'h0000} >> bitcnt_q);
                    bitcnt_d = bitcnt_q + 6'd16;
                    rd_ptr_d = rd_ptr_q + 18'd1;
                    state_d  = S_M3_DECODE;
                end
            end

            S_M3_DECODE: begin
                if (all_done_q) begin
                    // One cycle after the final write; leftover stream bits are dropped.
                    finish_d = 1'b1;
                    state_d  = S_M3_DONE;
                end else if (bitcnt_q < 6'd8) begin
                    state_d = S_M3_FILL;
                    addr_d  = rd_ptr_q;
                    phase_d = 3'd0;
                end else begin
                    unique case (prefix)
                        2'b00, 2'b01: begin
                            if (prefix[0]) begin
                                bitbuf_d = bitbuf_q << 8;
                                bitcnt_d = bitcnt_q - 6'd8;
                            end else begin
                                bitbuf_d = bitbuf_q << 5;
                                bitcnt_d = bitcnt_q - 6'd5;
                            end
                            we_n_d  = 1'b0;
                            addr_d  = wr_addr;
                            wdata_d = coef_out;
                            adv     = 1'b1;
                        end
                        2'b10: begin
                            bitbuf_d = bitbuf_q << 5;
                            bitcnt_d = bitcnt_q - 6'd5;
                            zcnt_d   = run_clip;
                            state_d  = S_M3_ZERO;
                        end
                        2'b11: begin
                            bitbuf_d = bitbuf_q << 2;
                            bitcnt_d = bitcnt_q - 6'd2;
                            zcnt_d   = remain;
                            state_d  = S_M3_ZERO;
                        end
                    endcase
                end
            end

            // zcnt_q is at least 1 on entry: a run is >= 1 and k never sits past 63.
            S_M3_ZERO: begin
                we_n_d  = 1'b0;
                addr_d  = wr_addr;
                wdata_d = 16'h0000;
                adv     = 1'b1;
                zcnt_d  = zcnt_q - 7'd1;
                if (zcnt_q == 7'd1) begin
                    state_d = S_M3_DECODE;
                end
            end

            S_M3_DONE: begin
                if (!M3_enable) begin
                    finish_d = 1'b0;
                    state_d  = S_M3_IDLE;
                end
            end

            default: begin
                state_d = S_M3_IDLE;
            end
        endcase

        // Step to the next scan position; a full block rolls over into the next block.
        if (adv) begin
            if (k_q == 6'd63) begin
                k_d   = 6'd0;
                blk_d = blk_q + 14'd1;
                if (blk_q == NUM_BLOCKS - 14'd1) begin
                    all_done_d = 1'b1;
                end
            end else begin
                k_d = k_q + 6'd1;
            end
        end
    end

    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_M3_IDLE;
            finish_q   <= 1'b0;
            error_q    <= 1'b0;
            we_n_q     <= 1'b1;
            addr_q     <= 18'd0;
            wdata_q    <= 16'd0;
            bitbuf_q   <= 32'd0;
            bitcnt_q   <= 6'd0;
            rd_ptr_q   <= 18'd0;
            phase_q    <= 3'd0;
            hdr_bad_q  <= 1'b0;
            k_q        <= 6'd0;
            blk_q      <= 14'd0;
            zcnt_q     <= 7'd0;
            all_done_q <= 1'b0;
`ifdef M3_DEQUANT_EN
            qsel_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            finish_q   <= finish_d;
            error_q    <= error_d;
            we_n_q     <= we_n_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            bitbuf_q   <= bitbuf_d;
            bitcnt_q   <= bitcnt_d;
            rd_ptr_q   <= rd_ptr_d;
            phase_q    <= phase_d;
            hdr_bad_q  <= hdr_bad_d;
            k_q        <= k_d;
            blk_q      <= blk_d;
            zcnt_q     <= zcnt_d;
            all_done_q <= all_done_d;
`ifdef M3_DEQUANT_EN
            qsel_q     <= qsel_d;
`endif
        end
    end

    assign M3_finish       = finish_q;
    assign M3_error        = error_q;
    assign SRAM_we_n       = we_n_q;
    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;

endmodule
